// File: rtl/sram1rw_arbiter_if.sv
// Client-side request/response bundle for sram1rw_arbiter: two valid/ready request
// ports plus their read-response channels.
interface sram1rw_arbiter_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 22
);
  logic              p0_req_valid;
  logic              p0_req_ready;
  logic              p0_req_write;
  logic [ADDR_W-1:0] p0_req_addr;
  logic [DATA_W-1:0] p0_req_wdata;
  logic              p0_resp_valid;
  logic [DATA_W-1:0] p0_resp_rdata;

  logic              p1_req_valid;
  logic              p1_req_ready;
  logic              p1_req_write;
  logic [ADDR_W-1:0] p1_req_addr;
  logic [DATA_W-1:0] p1_req_wdata;
  logic              p1_resp_valid;
  logic [DATA_W-1:0] p1_resp_rdata;

  modport master (
    output p0_req_valid, p0_req_write, p0_req_addr, p0_req_wdata,
    input  p0_req_ready, p0_resp_valid, p0_resp_rdata,
    output p1_req_valid, p1_req_write, p1_req_addr, p1_req_wdata,
    input  p1_req_ready, p1_resp_valid, p1_resp_rdata
  );

  modport slave (
    input  p0_req_valid, p0_req_write, p0_req_addr, p0_req_wdata,
    output p0_req_ready, p0_resp_valid, p0_resp_rdata,
    input  p1_req_valid, p1_req_write, p1_req_addr, p1_req_wdata,
    output p1_req_ready, p1_resp_valid, p1_resp_rdata
  );
endinterface

// File: rtl/sram1rw_arbiter.sv
// Two-port round-robin arbiter/sequencer for one SRAM1RW128x22 macro.
// Define SRAM1RW_ARB_INIT_SWEEP_EN to zero the array after reset before clients are served.
module sram1rw_arbiter #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 22,
  parameter int unsigned DEPTH  = 128
) (
  input  logic              clock,
  input  logic              reset_n,
  sram1rw_arbiter_if.slave  req,
  output logic              init_done,
  output logic              sram_ce,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_i,
  input  logic [DATA_W-1:0] sram_o
);

  localparam int unsigned LAST_ADDR = DEPTH - 1;

  if (DEPTH != (32'd1 << ADDR_W)) begin : g_depth_check
    $error("sram1rw_arbiter: DEPTH must equal 2**ADDR_W");
  end

  logic              run_c;
  logic              sweep_c;
  logic [ADDR_W-1:0] sweep_addr_c;
  logic [1:0]        grant_c;
  logic              prio_q, prio_d;
  logic [1:0]        resp_valid_q, resp_valid_d;

`ifdef SRAM1RW_ARB_INIT_SWEEP_EN
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_done_q, init_done_d;

  // Sweep FSM state register; any reset restarts the clear at address 0.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(LAST_ADDR)) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        init_done_d = 1'b1;
      end
    endcase
  end

  assign run_c        = reset_n && (state_q == ST_RUN);
  assign sweep_c      = reset_n && (state_q == ST_INIT);
  assign sweep_addr_c = cnt_q;
  assign init_done    = init_done_q;
`else
  assign run_c        = reset_n;
  assign sweep_c      = 1'b0;
  assign sweep_addr_c = '0;
  assign init_done    = 1'b1;
`endif

  // Round-robin grant: a lone requester always wins, a tie goes to prio_q.
  always_comb begin
    grant_c = 2'b00;
    if (run_c) begin
      if (req.p0_req_valid && (!req.p1_req_valid || !prio_q)) begin
        grant_c = 2'b01;
      end else if (req.p1_req_valid) begin
        grant_c = 2'b10;
      end
    end
  end

  // Pointer moves to the port that was not served; read grants schedule a response.
  always_comb begin
    prio_d       = prio_q;
    resp_valid_d = 2'b00;
    if (grant_c[0]) begin
      prio_d          = 1'b1;
      resp_valid_d[0] = !req.p0_req_write;
    end else if (grant_c[1]) begin
      prio_d          = 1'b0;
      resp_valid_d[1] = !req.p1_req_write;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prio_q       <= 1'b0;
      resp_valid_q <= 2'b00;
    end else begin
      prio_q       <= prio_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Macro controls follow the sweep or the current grant within the same cycle.
  always_comb begin
    sram_csb = 1'b1;
    sram_web = 1'b1;
    sram_oeb = 1'b1;
    sram_a   = '0;
    sram_i   = '0;
    if (sweep_c) begin
      sram_csb = 1'b0;
      sram_web = 1'b0;
      sram_a   = sweep_addr_c;
    end else if (grant_c[0]) begin
      sram_csb = 1'b0;
      sram_web = !req.p0_req_write;
      sram_oeb = req.p0_req_write;
      sram_a   = req.p0_req_addr;
      sram_i   = req.p0_req_wdata;
    end else if (grant_c[1]) begin
      sram_csb = 1'b0;
      sram_web = !req.p1_req_write;
      sram_oeb = req.p1_req_write;
      sram_a   = req.p1_req_addr;
      sram_i   = req.p1_req_wdata;
    end
  end

  assign sram_ce = clock;

  assign req.p0_req_ready = grant_c[0];
  assign req.p1_req_ready = grant_c[1];

  // A pulse already in flight is suppressed as soon as reset is asserted.
  assign req.p0_resp_valid = resp_valid_q[0] && reset_n;
  assign req.p1_resp_valid = resp_valid_q[1] && reset_n;
  assign req.p0_resp_rdata = sram_o;
  assign req.p1_resp_rdata = sram_o;

endmodule

// File: tb/tb_sram1rw_arbiter.sv
// Directed + constrained-random bench for sram1rw_arbiter with a behavioural macro model
// and a response scoreboard.
module tb_sram1rw_arbiter;
  localparam int unsigned AW    = 7;
  localparam int unsigned DW    = 22;
  localparam int unsigned DEPTH = 128;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_done, sram_ce, sram_csb, sram_web, sram_oeb;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_i, sram_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram1rw_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram1rw_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clock     (clk),
    .reset_n   (rst_n),
    .req       (bus),
    .init_done (init_done),
    .sram_ce   (sram_ce),
    .sram_csb  (sram_csb),
    .sram_web  (sram_web),
    .sram_oeb  (sram_oeb),
    .sram_a    (sram_a),
    .sram_i    (sram_i),
    .sram_o    (sram_o)
  );

  // Macro model: synchronous write, registered read output.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!sram_csb && !sram_web) mem[sram_a] <= sram_i;
    if (!sram_csb && !sram_oeb) sram_o <= mem[sram_a];
  end

  typedef struct {
    int            port;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb [$];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          prio_m;
  logic [AW-1:0] alist [5];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_resp();
    logic [1:0] exp_v;
    exp_t       e;
    bit         have;
    exp_v = 2'b00;
    have  = 1'b0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      have = 1'b1;
      exp_v[e.port] = 1'b1;
    end
    check("resp_valid", 32'({bus.p1_resp_valid, bus.p0_resp_valid}), 32'(exp_v));
    if (have)
      check("resp_rdata", 32'((e.port == 0) ? bus.p0_resp_rdata : bus.p1_resp_rdata), 32'(e.data));
  endtask

  // One RUN-state cycle: check last cycle's response, drive, check grant and macro drive.
  task automatic cycle(input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       output logic g0, output logic g1);
    logic [2:0]    exp_ctl;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_i;
    check_resp();
    bus.p0_req_valid = v0; bus.p0_req_write = w0; bus.p0_req_addr = a0; bus.p0_req_wdata = d0;
    bus.p1_req_valid = v1; bus.p1_req_write = w1; bus.p1_req_addr = a1; bus.p1_req_wdata = d1;
    #1;
    g0 = v0 && (!v1 || (prio_m == 1'b0));
    g1 = v1 && !g0;
    check("req_ready", 32'({bus.p1_req_ready, bus.p0_req_ready}), 32'({g1, g0}));
    exp_ctl = 3'b111; exp_a = '0; exp_i = '0;
    if (g0) begin
      exp_ctl = {1'b0, !w0, w0}; exp_a = a0; exp_i = d0;
      if (w0) ref_mem[a0] = d0; else sb.push_back('{0, ref_mem[a0]});
      prio_m = 1'b1;
    end else if (g1) begin
      exp_ctl = {1'b0, !w1, w1}; exp_a = a1; exp_i = d1;
      if (w1) ref_mem[a1] = d1; else sb.push_back('{1, ref_mem[a1]});
      prio_m = 1'b0;
    end
    check("sram_ctl", 32'({sram_csb, sram_web, sram_oeb}), 32'(exp_ctl));
    check("sram_a", 32'(sram_a), 32'(exp_a));
    check("sram_i", 32'(sram_i), 32'(exp_i));
    @(negedge clk);
  endtask

  task automatic idle();
    logic g0, g1;
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, g0, g1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic g0, g1, pend0, pend1, w0, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    alist[0] = 7'd0; alist[1] = 7'd1; alist[2] = 7'd2; alist[3] = 7'd5; alist[4] = 7'd127;
    prio_m = 1'b0;
    for (int k = 0; k < int'(DEPTH); k++) ref_mem[k] = '0;
    bus.p0_req_valid = 1'b1; bus.p0_req_write = 1'b0; bus.p0_req_addr = 7'd3; bus.p0_req_wdata = 22'h1;
    bus.p1_req_valid = 1'b1; bus.p1_req_write = 1'b1; bus.p1_req_addr = 7'd4; bus.p1_req_wdata = 22'h2;
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_ready", 32'({bus.p1_req_ready, bus.p0_req_ready}), 32'd0);
    check("rst_resp_valid", 32'({bus.p1_resp_valid, bus.p0_resp_valid}), 32'd0);
    check("rst_ctl", 32'({sram_csb, sram_web, sram_oeb}), 32'h7);
    check("rst_a", 32'(sram_a), 32'd0);
    check("rst_i", 32'(sram_i), 32'd0);
    check("rst_ce", 32'(sram_ce), 32'(clk));
`ifdef SRAM1RW_ARB_INIT_SWEEP_EN
    check("rst_init_done", 32'(init_done), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      #1;
      check("sweep_a", 32'(sram_a), 32'(k));
      check("sweep_ctl", 32'({sram_csb, sram_web, sram_oeb, bus.p1_req_ready, bus.p0_req_ready}), 32'b00100);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("sweep_rst_ctl", 32'({sram_csb, sram_web, sram_oeb}), 32'h7);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < int'(DEPTH); k++) begin
      #1;
      check("resweep_a", 32'(sram_a), 32'(k));
      check("resweep_busy", 32'({init_done, bus.p1_req_ready, bus.p0_req_ready}), 32'd0);
      if (k == int'(DEPTH) - 1) begin bus.p0_req_valid = 1'b0; bus.p1_req_valid = 1'b0; end
      @(negedge clk);
    end
    check("init_done_rise", 32'(init_done), 32'd1);
    cycle(1'b1, 1'b0, 7'd0, '0, 1'b0, 1'b0, '0, '0, g0, g1);
    cycle(1'b1, 1'b0, 7'd64, '0, 1'b0, 1'b0, '0, '0, g0, g1);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 7'd127, '0, g0, g1);
    idle();
`else
    check("rst_init_done", 32'(init_done), 32'd1);
    rst_n = 1'b1;
`endif
    // Write then read back on p0.
    cycle(1'b1, 1'b1, 7'd5, 22'h2ABCDE, 1'b0, 1'b0, '0, '0, g0, g1);
    cycle(1'b1, 1'b0, 7'd5, '0, 1'b0, 1'b0, '0, '0, g0, g1);
    idle();
    // Tie-break on saturated reads.
    cycle(1'b1, 1'b1, 7'd1, 22'h111111, 1'b0, 1'b0, '0, '0, g0, g1);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 7'd2, 22'h0A2B3C, g0, g1);
    for (int k = 0; k < 4; k++)
      cycle(1'b1, 1'b0, 7'd1, '0, 1'b1, 1'b0, 7'd2, '0, g0, g1);
    idle();
    // Cross-port write-then-read at the top address.
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 7'd127, 22'h000055, g0, g1);
    cycle(1'b1, 1'b0, 7'd127, '0, 1'b0, 1'b0, '0, '0, g0, g1);
    idle();
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 7'd0, 22'h3FFFFF, g0, g1);
    // Random traffic with clients holding requests until ready.
    pend0 = 1'b0; pend1 = 1'b0;
    w0 = 1'b0; w1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int n = 0; n < 40; n++) begin
      if (!pend0) begin
        pend0 = ($urandom_range(0, 3) != 0);
        w0 = 1'($urandom_range(0, 1)); a0 = alist[$urandom_range(0, 4)]; d0 = DW'($urandom);
      end
      if (!pend1) begin
        pend1 = ($urandom_range(0, 3) != 0);
        w1 = 1'($urandom_range(0, 1)); a1 = alist[$urandom_range(0, 4)]; d1 = DW'($urandom);
      end
      cycle(pend0, w0, a0, d0, pend1, w1, a1, d1, g0, g1);
      if (g0) pend0 = 1'b0;
      if (g1) pend1 = 1'b0;
    end
    idle();
    // Reset right after a read grant drops the response.
    cycle(1'b1, 1'b0, 7'd5, '0, 1'b0, 1'b0, '0, '0, g0, g1);
    rst_n = 1'b0;
    #1;
    check("rstrd_resp_valid", 32'({bus.p1_resp_valid, bus.p0_resp_valid}), 32'd0);
    check("rstrd_ctl", 32'({sram_csb, sram_web, sram_oeb}), 32'h7);
    check("rstrd_ready", 32'({bus.p1_req_ready, bus.p0_req_ready}), 32'd0);
    sb.delete();
    @(negedge clk);
    check("rstrd_resp_valid2", 32'({bus.p1_resp_valid, bus.p0_resp_valid}), 32'd0);
    rst_n = 1'b1;
    prio_m = 1'b0;
`ifdef SRAM1RW_ARB_INIT_SWEEP_EN
    bus.p0_req_valid = 1'b0;
    for (int k = 0; k < int'(DEPTH); k++) ref_mem[k] = '0;
    for (int k = 0; k < 300 && !init_done; k++) @(negedge clk);
    check("init_done_after_reset", 32'(init_done), 32'd1);
`endif
    cycle(1'b1, 1'b0, 7'd5, '0, 1'b1, 1'b0, 7'd127, '0, g0, g1);
    cycle(1'b1, 1'b0, 7'd5, '0, 1'b1, 1'b0, 7'd127, '0, g0, g1);
    idle();
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
